// File: rtl/tt_deframer_pkg.sv
// Shared types and defaults for the dibit deframer tile.
package tt_deframer_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;
    localparam int         FRAME_LEN_DEF = 4;
    localparam int         MISS_MAX_DEF  = 2;
    localparam int         FRAME_LEN_W   = 4;
    localparam int         MISS_W        = 2;

    function automatic logic [3:0] nibble_sel(input logic [7:0] byte_v, input logic hi_v);
        return hi_v ? byte_v[7:4] : byte_v[3:0];
    endfunction

endpackage

// File: rtl/tt_dibit_window.sv
// 8-bit dibit shift window with a 2-bit symbol counter; flags the 4th symbol of each byte.
module tt_dibit_window (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sym_valid_i,
    input  logic [1:0] dibit_i,
    input  logic       cnt_clr_i,
    output logic [7:0] window_next_o,
    output logic       byte_done_o
);

    logic [7:0] window_q;
    logic [1:0] sym_cnt_q;

    assign window_next_o = {window_q[5:0], dibit_i};
    assign byte_done_o   = sym_valid_i && (sym_cnt_q == 2'd3);

    // Shift in each qualified symbol; a sync hit realigns the counter to a byte boundary
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            window_q  <= 8'h00;
            sym_cnt_q <= 2'd0;
        end else if (sym_valid_i) begin
            window_q  <= window_next_o;
            sym_cnt_q <= cnt_clr_i ? 2'd0 : sym_cnt_q + 2'd1;
        end else begin
            window_q  <= window_q;
            sym_cnt_q <= sym_cnt_q;
        end
    end

endmodule

// File: rtl/tt_dibit_deframer.sv
// Dibit deframer tile: hunts for the sync byte, verifies alignment, then
// presents payload bytes nibble-wise with a one-cycle strobe.
module tt_dibit_deframer
    import tt_deframer_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter int         FRAME_LEN = FRAME_LEN_DEF,
    parameter int         MISS_MAX  = MISS_MAX_DEF
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic       clk_s;
    logic       rst_s;
    logic [1:0] dibit_s;
    logic       sym_valid_s;
    logic       nib_sel_s;
    logic       clr_err_s;
    logic       unused_s;

    assign clk_s       = io_in[0];
    assign rst_s       = io_in[1];
    assign dibit_s     = io_in[3:2];
    assign sym_valid_s = io_in[4];
    assign nib_sel_s   = io_in[5];
    assign clr_err_s   = io_in[6];
    assign unused_s    = io_in[7];

    state_t                 state_q;
    logic [FRAME_LEN_W-1:0] byte_cnt_q;
    logic [MISS_W-1:0]      miss_cnt_q;
    logic [7:0]             data_q;
    logic                   strobe_q;
    logic                   sync_err_q;
    logic                   locked_q;
    logic                   hunting_q;

    logic [7:0] window_next_s;
    logic       byte_done_s;
    logic       sync_hit_s;
    logic       sync_slot_s;
    logic       cnt_clr_s;
    logic       lose_lock_s;

    assign sync_hit_s  = (window_next_s == SYNC_WORD);
    assign sync_slot_s = (byte_cnt_q == FRAME_LEN_W'(FRAME_LEN));
    assign cnt_clr_s   = (state_q == HUNT) && sync_hit_s;
    // Lock is lost on the sync-slot miss that brings the miss count up to MISS_MAX
    assign lose_lock_s = (state_q == LOCKED) && byte_done_s && sync_slot_s && !sync_hit_s
                         && ((miss_cnt_q + MISS_W'(1)) == MISS_W'(MISS_MAX));

    tt_dibit_window u_window (
        .clk_i        (clk_s),
        .rst_i        (rst_s),
        .sym_valid_i  (sym_valid_s),
        .dibit_i      (dibit_s),
        .cnt_clr_i    (cnt_clr_s),
        .window_next_o(window_next_s),
        .byte_done_o  (byte_done_s)
    );

    // Framing FSM with counters, payload register, strobe, sticky error and state decodes
    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            state_q    <= HUNT;
            byte_cnt_q <= '0;
            miss_cnt_q <= '0;
            data_q     <= 8'h00;
            strobe_q   <= 1'b0;
            sync_err_q <= 1'b0;
            locked_q   <= 1'b0;
            hunting_q  <= 1'b1;
        end else begin
            strobe_q   <= 1'b0;
            sync_err_q <= lose_lock_s ? 1'b1 : (clr_err_s ? 1'b0 : sync_err_q);
            if (sym_valid_s) begin
                case (state_q)
                    HUNT: begin
                        if (sync_hit_s) begin
                            state_q    <= VERIFY;
                            byte_cnt_q <= '0;
                            hunting_q  <= 1'b0;
                            locked_q   <= 1'b0;
                        end
                    end
                    VERIFY: begin
                        if (byte_done_s) begin
                            if (sync_slot_s) begin
                                byte_cnt_q <= '0;
                                if (sync_hit_s) begin
                                    state_q    <= LOCKED;
                                    miss_cnt_q <= '0;
                                    locked_q   <= 1'b1;
                                    hunting_q  <= 1'b0;
                                end else begin
                                    state_q    <= HUNT;
                                    locked_q   <= 1'b0;
                                    hunting_q  <= 1'b1;
                                end
                            end else begin
                                byte_cnt_q <= byte_cnt_q + FRAME_LEN_W'(1);
                            end
                        end
                    end
                    LOCKED: begin
                        if (byte_done_s) begin
                            if (sync_slot_s) begin
                                // A missed sync still occupies the slot so frame timing is kept
                                byte_cnt_q <= '0;
                                if (sync_hit_s) begin
                                    miss_cnt_q <= '0;
                                end else if (lose_lock_s) begin
                                    state_q    <= HUNT;
                                    miss_cnt_q <= '0;
                                    locked_q   <= 1'b0;
                                    hunting_q  <= 1'b1;
                                end else begin
                                    miss_cnt_q <= miss_cnt_q + MISS_W'(1);
                                end
                            end else begin
                                data_q     <= window_next_s;
                                strobe_q   <= 1'b1;
                                byte_cnt_q <= byte_cnt_q + FRAME_LEN_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q    <= HUNT;
                        byte_cnt_q <= '0;
                        miss_cnt_q <= '0;
                        locked_q   <= 1'b0;
                        hunting_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign io_out = {hunting_q, sync_err_q, strobe_q, locked_q, nibble_sel(data_q, nib_sel_s)};

endmodule

// File: tb/tb_tt_dibit_deframer.sv
// Scoreboard bench for tt_dibit_deframer: payload bytes sent while locked are
// queued and popped when the strobe appears.
module tb_tt_dibit_deframer;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       valid   = 1'b0;
    logic [1:0] dibit   = 2'b00;
    logic       nib_sel = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] exp_q[$];

    assign io_in = {1'b0, clr_err, nib_sel, valid, dibit, rst, clk};

    tt_dibit_deframer dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Called #1 after each rising edge: a strobe must match the oldest queued byte
    task automatic sample();
        logic [7:0] e;
        if (io_out[5] === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_strobe", {7'd0, io_out[5]}, 8'h00);
            end else begin
                e = exp_q.pop_front();
                nib_sel = 1'b0;
                #1 chk("lo_nibble", {4'h0, io_out[3:0]}, {4'h0, e[3:0]});
                nib_sel = 1'b1;
                #1 chk("hi_nibble", {4'h0, io_out[3:0]}, {4'h0, e[7:4]});
                nib_sel = 1'b0;
            end
        end
    endtask

    task automatic step(input logic v, input logic [1:0] d, input logic c);
        @(negedge clk);
        valid   = v;
        dibit   = d;
        clr_err = c;
        @(posedge clk);
        #1;
        sample();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit push, input int gap, input logic clr_last);
        if (push) exp_q.push_back(b);
        for (int i = 3; i >= 0; i--) begin
            repeat ($urandom_range(gap, 0)) step(1'b0, 2'b00, 1'b0);
            step(1'b1, b[2*i+1 -: 2], (i == 0) ? clr_last : 1'b0);
        end
    endtask

    task automatic send_frame(input logic [31:0] pl, input logic [7:0] sync, input bit push,
                              input int gap, input logic clr_last);
        for (int k = 3; k >= 0; k--) send_byte(pl[8*k+7 -: 8], push, gap, 1'b0);
        send_byte(sync, 1'b0, gap, clr_last);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        valid   = 1'b0;
        clr_err = 1'b0;
        @(posedge clk);
        #1 chk("reset_out", io_out, 8'h80);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic relock(input int gap);
        send_byte(8'hA5, 1'b0, gap, 1'b0);
        chk("verify_flags", {4'h0, io_out[7:4]}, 8'h00);
        send_frame(32'h11223344, 8'hA5, 1'b0, gap, 1'b0);
        chk("lock_flags", {4'h0, io_out[7:4]}, 8'h01);
    endtask

    initial begin
        do_reset();
        repeat (8) step(1'b0, 2'b00, 1'b0);
        chk("idle_out", io_out, 8'h80);

        relock(0);
        send_frame(32'h3CA50FF0, 8'hA5, 1'b1, 0, 1'b0);
        chk("locked_after_frame", {4'h0, io_out[7:4]}, 8'h01);

        send_frame(32'h12345678, 8'h00, 1'b1, 0, 1'b0);
        chk("one_miss_flags", {4'h0, io_out[7:4]}, 8'h01);
        send_frame(32'h9ABCDEF1, 8'hA5, 1'b1, 0, 1'b0);
        chk("recovered_flags", {4'h0, io_out[7:4]}, 8'h01);

        send_frame(32'h01020304, 8'h00, 1'b1, 0, 1'b0);
        chk("miss1_flags", {4'h0, io_out[7:4]}, 8'h01);
        send_frame(32'hC3D2E1F0, 8'h00, 1'b1, 0, 1'b0);
        chk("lost_lock_flags", {4'h0, io_out[7:4]}, 8'h0C);
        repeat (3) step(1'b0, 2'b00, 1'b0);
        chk("err_sticky", {4'h0, io_out[7:4]}, 8'h0C);
        step(1'b0, 2'b00, 1'b1);
        chk("err_cleared", {4'h0, io_out[7:4]}, 8'h08);

        relock(0);
        send_frame(32'h55667788, 8'h00, 1'b1, 0, 1'b0);
        send_frame(32'h99AABBCC, 8'h00, 1'b1, 0, 1'b1);
        chk("set_wins", {4'h0, io_out[7:4]}, 8'h0C);
        step(1'b0, 2'b00, 1'b1);
        chk("err_cleared2", {4'h0, io_out[7:4]}, 8'h08);

        relock(2);
        send_frame(32'h3CA50FF0, 8'hA5, 1'b1, 2, 1'b0);
        chk("gap_locked", {4'h0, io_out[7:4]}, 8'h01);

        send_byte(8'h3C, 1'b1, 0, 1'b0);
        step(1'b1, 2'b01, 1'b0);
        step(1'b1, 2'b10, 1'b0);
        do_reset();
        repeat (4) step(1'b0, 2'b00, 1'b0);
        chk("post_reset_out", io_out, 8'h80);
        chk("queue_drained", 8'(exp_q.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
